// File: rtl/pipe_hazard_ctrl.sv
// Hazard scheduler for a 5-stage non-forwarding pipeline: RAW stall, redirect flush, memory freeze.
// Stall/flush outputs are combinational and same-cycle; slots, FSM, and counters update on posedge i_clk.
module pipe_hazard_ctrl #(
  parameter int WB_BYPASS   = 1,
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_id_valid,
  input  logic [4:0]       i_id_rs1,
  input  logic [4:0]       i_id_rs2,
  input  logic             i_id_rs1_used,
  input  logic             i_id_rs2_used,
  input  logic [4:0]       i_id_rd,
  input  logic             i_id_regwen,
  input  logic             i_ex_redirect,
  input  logic             i_mem_req,
  input  logic             i_mem_ready,
  output logic             o_stall_pc,
  output logic             o_stall_ifid,
  output logic             o_stall_idex,
  output logic             o_stall_exmem,
  output logic             o_flush_ifid,
  output logic             o_flush_idex,
  output logic             o_flush_memwb,
  output logic             o_mem_timeout,
  output logic [1:0]       o_state,
  output logic [CNT_W-1:0] o_stall_cnt,
  output logic [CNT_W-1:0] o_flush_cnt
);

  localparam int TO_W = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [1:0] {RUN = 2'b00, RAW_STALL = 2'b01, MEM_WAIT = 2'b10} state_t;

  state_t            state_q, state_d;
  logic              ex_vld_q, mem_vld_q, wb_vld_q;
  logic [4:0]        ex_rd_q, mem_rd_q, wb_rd_q;
  logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

  logic freeze, redirect, raw, issue;
  logic raw_ex, raw_mem, raw_wb;

  function automatic logic src_hit(input logic [4:0] rs, input logic used,
                                   input logic vld, input logic [4:0] rd);
    return used && (rs != 5'd0) && vld && (rs == rd);
  endfunction

  assign raw_ex  = src_hit(i_id_rs1, i_id_rs1_used, ex_vld_q, ex_rd_q)
                 | src_hit(i_id_rs2, i_id_rs2_used, ex_vld_q, ex_rd_q);
  assign raw_mem = src_hit(i_id_rs1, i_id_rs1_used, mem_vld_q, mem_rd_q)
                 | src_hit(i_id_rs2, i_id_rs2_used, mem_vld_q, mem_rd_q);
  assign raw_wb  = src_hit(i_id_rs1, i_id_rs1_used, wb_vld_q, wb_rd_q)
                 | src_hit(i_id_rs2, i_id_rs2_used, wb_vld_q, wb_rd_q);

  assign freeze   = i_mem_req & ~i_mem_ready;
  assign redirect = i_ex_redirect;
  assign raw      = i_id_valid & (raw_ex | raw_mem | ((WB_BYPASS == 0) & raw_wb));
  assign issue    = ~redirect & ~raw;

  // Outputs are qualified with i_rst_n so they collapse during reset without a clock edge.
  always_comb begin
    o_stall_pc    = 1'b0;
    o_stall_ifid  = 1'b0;
    o_stall_idex  = 1'b0;
    o_stall_exmem = 1'b0;
    o_flush_ifid  = 1'b0;
    o_flush_idex  = 1'b0;
    o_flush_memwb = 1'b0;
    if (i_rst_n) begin
      if (freeze) begin
        o_stall_pc    = 1'b1;
        o_stall_ifid  = 1'b1;
        o_stall_idex  = 1'b1;
        o_stall_exmem = 1'b1;
        o_flush_memwb = 1'b1;
      end else if (redirect) begin
        o_flush_ifid = 1'b1;
        o_flush_idex = 1'b1;
      end else if (raw) begin
        o_stall_pc   = 1'b1;
        o_stall_ifid = 1'b1;
        o_flush_idex = 1'b1;
      end
    end
  end

  assign o_mem_timeout = i_rst_n & freeze & (to_cnt_q == TO_W'(MEM_TIMEOUT - 1));
  assign o_state       = state_q;
  assign o_stall_cnt   = stall_cnt_q;
  assign o_flush_cnt   = flush_cnt_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:       if (freeze) state_d = MEM_WAIT;
                 else if (raw && !redirect) state_d = RAW_STALL;
      RAW_STALL: if (freeze) state_d = MEM_WAIT;
                 else if (!raw) state_d = RUN;
      MEM_WAIT:  if (!freeze) state_d = RUN;
      default:   state_d = RUN;
    endcase
  end

  // Wait counter saturates at MEM_TIMEOUT so the timeout pulse fires only once per wait.
  always_comb begin
    to_cnt_d = '0;
    if (freeze) begin
      to_cnt_d = (to_cnt_q == TO_W'(MEM_TIMEOUT)) ? to_cnt_q : to_cnt_q + TO_W'(1);
    end
    stall_cnt_d = stall_cnt_q;
    if (o_stall_pc && !(&stall_cnt_q)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    flush_cnt_d = flush_cnt_q;
    if (redirect && !freeze && !(&flush_cnt_q)) flush_cnt_d = flush_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= RUN;
      ex_vld_q    <= 1'b0;
      mem_vld_q   <= 1'b0;
      wb_vld_q    <= 1'b0;
      ex_rd_q     <= 5'd0;
      mem_rd_q    <= 5'd0;
      wb_rd_q     <= 5'd0;
      to_cnt_q    <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      to_cnt_q    <= to_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      if (!freeze) begin
        wb_vld_q  <= mem_vld_q;
        wb_rd_q   <= mem_rd_q;
        mem_vld_q <= ex_vld_q;
        mem_rd_q  <= ex_rd_q;
        ex_vld_q  <= issue & i_id_valid & i_id_regwen & (i_id_rd != 5'd0);
        ex_rd_q   <= i_id_rd;
      end
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: RAW stall, x0, redirect, memory freeze, timeout, async reset.
module tb_pipe_hazard_ctrl;

  logic        i_clk, i_rst_n;
  logic        i_id_valid, i_id_rs1_used, i_id_rs2_used, i_id_regwen;
  logic [4:0]  i_id_rs1, i_id_rs2, i_id_rd;
  logic        i_ex_redirect, i_mem_req, i_mem_ready;
  logic        o_stall_pc, o_stall_ifid, o_stall_idex, o_stall_exmem;
  logic        o_flush_ifid, o_flush_idex, o_flush_memwb, o_mem_timeout;
  logic [1:0]  o_state;
  logic [15:0] o_stall_cnt, o_flush_cnt;

  int errs   = 0;
  int checks = 0;

  pipe_hazard_ctrl #(.WB_BYPASS(1), .MEM_TIMEOUT(4), .CNT_W(16)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_id_valid(i_id_valid), .i_id_rs1(i_id_rs1), .i_id_rs2(i_id_rs2),
    .i_id_rs1_used(i_id_rs1_used), .i_id_rs2_used(i_id_rs2_used),
    .i_id_rd(i_id_rd), .i_id_regwen(i_id_regwen),
    .i_ex_redirect(i_ex_redirect), .i_mem_req(i_mem_req), .i_mem_ready(i_mem_ready),
    .o_stall_pc(o_stall_pc), .o_stall_ifid(o_stall_ifid), .o_stall_idex(o_stall_idex),
    .o_stall_exmem(o_stall_exmem), .o_flush_ifid(o_flush_ifid), .o_flush_idex(o_flush_idex),
    .o_flush_memwb(o_flush_memwb), .o_mem_timeout(o_mem_timeout), .o_state(o_state),
    .o_stall_cnt(o_stall_cnt), .o_flush_cnt(o_flush_cnt)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic id_set(input logic vld, input logic [4:0] rs1, input logic u1,
                        input logic [4:0] rs2, input logic u2,
                        input logic [4:0] rd, input logic wen);
    i_id_valid = vld; i_id_rs1 = rs1; i_id_rs1_used = u1;
    i_id_rs2 = rs2; i_id_rs2_used = u2; i_id_rd = rd; i_id_regwen = wen;
  endtask

  task automatic drain();
    id_set(0, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) tick();
  endtask

  initial begin
    id_set(0, 0, 0, 0, 0, 0, 0);
    i_ex_redirect = 0; i_mem_ready = 0; i_mem_req = 1; i_rst_n = 0;
    #12;
    // Reset: freeze request present but outputs must stay low.
    check("rst_state", o_state, 0);
    check("rst_stall_pc", o_stall_pc, 0);
    check("rst_flush_memwb", o_flush_memwb, 0);
    check("rst_stall_cnt", o_stall_cnt, 0);
    check("rst_flush_cnt", o_flush_cnt, 0);
    i_mem_req = 0;
    i_rst_n = 1;
    tick();

    // T1: producer x5, consumer rs1=x5 stalls two cycles.
    id_set(1, 0, 0, 0, 0, 5, 1);
    @(negedge i_clk); check("t1_prod_nostall", o_stall_pc, 0);
    tick();
    id_set(1, 5, 1, 0, 0, 6, 1);
    @(negedge i_clk);
    check("t1_c1_stall_pc", o_stall_pc, 1);
    check("t1_c1_stall_ifid", o_stall_ifid, 1);
    check("t1_c1_flush_idex", o_flush_idex, 1);
    check("t1_c1_state", o_state, 0);
    tick();
    @(negedge i_clk);
    check("t1_c2_stall_pc", o_stall_pc, 1);
    check("t1_c2_state", o_state, 1);
    tick();
    @(negedge i_clk);
    check("t1_c3_stall_pc", o_stall_pc, 0);
    check("t1_c3_flush_idex", o_flush_idex, 0);
    check("t1_stall_cnt", o_stall_cnt, 2);
    tick();
    drain();

    // T2: x0 never creates a hazard.
    id_set(1, 0, 0, 0, 0, 0, 1);
    tick();
    id_set(1, 0, 1, 0, 1, 7, 1);
    @(negedge i_clk);
    check("t2_stall_pc", o_stall_pc, 0);
    tick();
    @(negedge i_clk);
    check("t2_state", o_state, 0);
    drain();

    // T3: redirect overrides a pending RAW on rs2.
    id_set(1, 0, 0, 0, 0, 9, 1);
    tick();
    id_set(1, 0, 0, 9, 1, 10, 1);
    i_ex_redirect = 1;
    @(negedge i_clk);
    check("t3_flush_ifid", o_flush_ifid, 1);
    check("t3_flush_idex", o_flush_idex, 1);
    check("t3_stall_pc", o_stall_pc, 0);
    tick();
    i_ex_redirect = 0;
    id_set(1, 10, 1, 0, 0, 0, 0);
    @(negedge i_clk);
    check("t3_ex_slot_empty", o_stall_pc, 0);
    check("t3_flush_cnt", o_flush_cnt, 1);
    check("t3_state", o_state, 0);
    tick();
    drain();

    // T4: three-cycle freeze with x12 parked in EX.
    id_set(1, 0, 0, 0, 0, 12, 1);
    tick();
    id_set(0, 0, 0, 0, 0, 0, 0);
    i_mem_req = 1; i_mem_ready = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge i_clk);
      check("t4_stall_pc", o_stall_pc, 1);
      check("t4_stall_exmem", o_stall_exmem, 1);
      check("t4_stall_idex", o_stall_idex, 1);
      check("t4_flush_memwb", o_flush_memwb, 1);
      check("t4_flush_idex", o_flush_idex, 0);
      check("t4_state", o_state, (c == 0) ? 0 : 2);
      check("t4_timeout", o_mem_timeout, 0);
      tick();
    end
    i_mem_req = 0;
    id_set(1, 12, 1, 0, 0, 0, 0);
    @(negedge i_clk);
    check("t4_slot_held_raw", o_stall_pc, 1);
    check("t4_flush_memwb_off", o_flush_memwb, 0);
    tick();
    id_set(0, 0, 0, 0, 0, 0, 0);
    @(negedge i_clk);
    check("t4_stall_cnt", o_stall_cnt, 6);
    check("t4_state_run", o_state, 0);
    tick();
    drain();

    // T5: timeout pulses on the 4th wait cycle only; freeze persists.
    i_mem_req = 1; i_mem_ready = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge i_clk);
      check("t5_timeout", o_mem_timeout, (c == 3) ? 1 : 0);
      check("t5_freeze", o_stall_pc, 1);
      tick();
    end
    check("t5_stall_cnt", o_stall_cnt, 12);
    check("t5_state", o_state, 2);

    // T6: async reset mid-wait clears everything without a clock edge.
    i_rst_n = 0;
    #2;
    check("t6_state", o_state, 0);
    check("t6_stall_pc", o_stall_pc, 0);
    check("t6_flush_memwb", o_flush_memwb, 0);
    check("t6_timeout", o_mem_timeout, 0);
    check("t6_stall_cnt", o_stall_cnt, 0);
    check("t6_flush_cnt", o_flush_cnt, 0);
    i_mem_req = 0;
    #3;
    i_rst_n = 1;
    tick();
    @(negedge i_clk);
    check("t6_post_state", o_state, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
